// File: rtl/tt_um_seq_divider.sv
// tt_um_seq_divider: sequential 8-bit / 4-bit unsigned restoring divider.
// One quotient bit per clock, MSB first, with a start/busy/done handshake
// on the bidirectional pins. Optional feature macro: DIV_REMAINDER_EN
// (remainder output register and quotient/remainder select mux).
module tt_um_seq_divider (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  divisor_in;
    logic        start;
    logic        accept;
    logic        busy;
    logic        done;

    // Working registers: dvd shifts left, quotient bits enter at the LSB,
    // so after eight steps dvd holds the quotient.
    logic [7:0]  dvd;
    logic [3:0]  dsr;
    logic [4:0]  partial;
    logic [2:0]  count;

    // Registered results, only updated at completion so no partial value leaks.
    logic [7:0]  quotient;
`ifdef DIV_REMAINDER_EN
    logic [3:0]  remainder;
`endif

    logic [4:0]  shifted;
    logic        take;
    logic [4:0]  partial_step;
    logic [7:0]  dvd_step;

    assign divisor_in = uio_in[3:0];
    assign start      = uio_in[4];
    assign accept     = start && (state != CALC);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and handshake flags.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor_in == 4'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == 3'd7) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = (divisor_in == 4'd0) ? DONE : CALC;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One restoring shift-subtract step.
    always_comb begin
        shifted      = {partial[3:0], dvd[7]};
        take         = (shifted >= {1'b0, dsr});
        partial_step = take ? (shifted - {1'b0, dsr}) : shifted;
        dvd_step     = {dvd[6:0], take};
    end

    // Operand latch, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd       <= '0;
            dsr       <= '0;
            partial   <= '0;
            count     <= '0;
            quotient  <= '0;
`ifdef DIV_REMAINDER_EN
            remainder <= '0;
`endif
        end else if (accept) begin
            dvd     <= ui_in;
            dsr     <= divisor_in;
            partial <= '0;
            count   <= '0;
            if (divisor_in == 4'd0) begin
                quotient  <= 8'hFF;
`ifdef DIV_REMAINDER_EN
                remainder <= 4'h0;
`endif
            end
        end else if (state == CALC) begin
            dvd     <= dvd_step;
            partial <= partial_step;
            count   <= count + 3'd1;
            if (count == 3'd7) begin
                quotient  <= dvd_step;
`ifdef DIV_REMAINDER_EN
                remainder <= partial_step[3:0];
`endif
            end
        end
    end

`ifdef DIV_REMAINDER_EN
    assign uo_out = uio_in[5] ? {4'b0000, remainder} : quotient;
    logic unused;
    assign unused = &{1'b0, ena, uio_in[7:6], partial[4]};
`else
    assign uo_out = quotient;
    logic unused;
    assign unused = &{1'b0, ena, uio_in[7:5], partial[4]};
`endif

    assign uio_out = {done, busy, 6'b00_0000};
    assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_seq_divider.sv
// Directed bench for tt_um_seq_divider: handshake timing, known quotients and
// remainders, divide-by-zero, ignored start during CALC, back-to-back starts,
// asynchronous reset abort and an exhaustive operand sweep.
module tb_tt_um_seq_divider;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [3:0] dsr;
    logic       start;
    logic       sel;
    logic       ena;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int failures;

    assign uio_in = {2'b00, sel, start, dsr};

    tt_um_seq_divider dut (
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .ena     (ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done; returns the number of edges waited.
    task automatic wait_done(output int lat);
        lat = 0;
        while (uio_out[7] !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    // Pulses start for one accept edge and leaves the bench just after it.
    task automatic launch(input logic [7:0] a, input logic [3:0] d);
        ui_in = a;
        dsr   = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks both mux views of the result; sel changes take effect with no clock.
    task automatic check_result(input string tag, input logic [7:0] q, input logic [3:0] r);
        sel = 1'b0;
        #1;
        check({tag, "_quot"}, uo_out, q);
        sel = 1'b1;
        #1;
`ifdef DIV_REMAINDER_EN
        check({tag, "_rem"}, uo_out, {4'b0000, r});
`else
        check({tag, "_selq"}, uo_out, q);
`endif
        sel = 1'b0;
        #1;
    endtask

    initial begin
        int lat;
        logic [7:0] expq;
        logic [3:0] expr;

        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ui_in    = '0;
        dsr      = '0;
        start    = 1'b0;
        sel      = 1'b0;
        ena      = 1'b1;

        #2;
        check("rst_uo_out", uo_out, 8'h00);
        check("rst_uio_out", uio_out, 8'h00);
        check("uio_oe", uio_oe, 8'hC0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_uio_out", uio_out, 8'h00);

        // 225 / 15 = 15 r 0, with full latency/busy checks.
        launch(8'hE1, 4'hF);
        check("e1_busy_after_e0", uio_out, 8'h40);
        for (int i = 1; i < 8; i++) begin
            tick();
            check("e1_busy_steady", uio_out, 8'h40);
        end
        tick();
        check("e1_done_after_e8", uio_out, 8'h80);
        check_result("e1_div_f", 8'h0F, 4'h0);

        // Result holds in DONE.
        tick();
        tick();
        check("e1_done_hold", uio_out, 8'h80);
        check("e1_quot_hold", uo_out, 8'h0F);

        // 200 / 7 = 28 r 4.
        launch(8'd200, 4'd7);
        check("200_7_result_not_exposed", uo_out, 8'h0F);
        wait_done(lat);
        check("200_7_latency", 8'(lat), 8'd8);
        check_result("200_7", 8'h1C, 4'h4);

        // 9 / 10 = 0 r 9.
        launch(8'd9, 4'd10);
        wait_done(lat);
        check("9_10_latency", 8'(lat), 8'd8);
        check_result("9_10", 8'h00, 4'h9);

        // Divide by zero: done immediately, busy never.
        launch(8'h5A, 4'h0);
        check("div0_flags", uio_out, 8'h80);
        check_result("div0", 8'hFF, 4'h0);
        tick();
        check("div0_flags_hold", uio_out, 8'h80);

        // Start during CALC with new operands is ignored.
        launch(8'd40, 4'd3);
        tick();
        tick();
        tick();
        ui_in = 8'd255;
        dsr   = 4'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ignore_still_busy", uio_out, 8'h40);
        wait_done(lat);
        check("ignore_latency", 8'(lat), 8'd4);
        check_result("40_3", 8'h0D, 4'h1);

        // Start held high from DONE: new op on the next edge, every 9 cycles.
        start = 1'b1;
        tick();
        check("b2b_busy", uio_out, 8'h40);
        wait_done(lat);
        check("b2b_latency", 8'(lat), 8'd8);
        check_result("255_1", 8'hFF, 4'h0);
        tick();
        check("b2b_restart_busy", uio_out, 8'h40);
        wait_done(lat);
        check("b2b_period", 8'(lat + 1), 8'd9);
        start = 1'b0;

        // Asynchronous reset in the 4th CALC cycle aborts with nothing exposed.
        launch(8'd200, 4'd7);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_uo_out", uo_out, 8'h00);
        check("abort_uio_out", uio_out, 8'h00);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_idle", uio_out, 8'h00);
        check("abort_uo_idle", uo_out, 8'h00);
        launch(8'd100, 4'd9);
        check("post_rst_busy", uio_out, 8'h40);
        wait_done(lat);
        check("post_rst_latency", 8'(lat), 8'd8);
        check_result("100_9", 8'h0B, 4'h1);

        // Exhaustive sweep against the arithmetic reference.
        for (int a = 0; a < 256; a++) begin
            for (int d = 0; d < 16; d++) begin
                launch(8'(a), 4'(d));
                wait_done(lat);
                if (d == 0) begin
                    expq = 8'hFF;
                    expr = 4'h0;
                end else begin
                    expq = 8'(a / d);
                    expr = 4'(a % d);
                end
                check("sweep_done", {7'b0, uio_out[7]}, 8'h01);
                sel = 1'b0;
                #1;
                check("sweep_quot", uo_out, expq);
`ifdef DIV_REMAINDER_EN
                sel = 1'b1;
                #1;
                check("sweep_rem", uo_out, {4'b0000, expr});
                sel = 1'b0;
`else
                if (expr > 4'd15) begin
                    check("sweep_rem_range", {4'b0000, expr}, 8'h00);
                end
`endif
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tt_um_seq_divider.md
# tt_um_seq_divider

Sequential 8-bit by 4-bit unsigned divider, packaged as a Tiny Tapeout user module alongside the combinational 4x4 multiplier. It performs the inverse operation: given an 8-bit dividend (for example a multiplier product) and a 4-bit divisor, it recovers the quotient and remainder. It uses a restoring shift-subtract algorithm, one quotient bit per clock, with a start/busy/done handshake on the bidirectional pins.

## Interface
- No parameters.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ui_in  input  8  dividend
- uio_in  input  8
  - [3:0] divisor
  - [4] start
  - [5] result select: 0 = quotient, 1 = remainder
  - [7:6] ignored
- uo_out  output  8  selected result
- uio_out  output  8
  - [6] busy
  - [7] done
  - [5:0] driven 0
- uio_oe  output  8  constant 8'b1100_0000
- ena  input  1  unused; tied into the unused-signal reduction

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE.
- **Start accept (IDLE or DONE, start=1 at a rising edge):**
  - Latch ui_in into the dividend register and uio_in[3:0] into the divisor register.
  - Clear the 5-bit partial remainder and the 3-bit iteration counter.
  - Clear done.
- **Divisor nonzero:** go to CALC and set busy=1.
- **Divisor zero:** go directly to DONE with quotient=8'hFF, remainder=4'h0, done=1.
- **CALC step (one per edge, MSB first):**
  - partial = {partial[3:0], dividend_msb}.
  - If partial >= {1'b0, divisor}: subtract the divisor and shift 1 into the quotient.
  - Otherwise shift 0 into the quotient.
  - Increment the counter.
- **End of CALC:** after the 8th step, go to DONE. Registered outputs: quotient = full 8 bits, remainder = partial[3:0], busy=0, done=1.
- **DONE:** results and done=1 hold until the next accepted start.
- **start=1 during CALC:** ignored. Operand inputs are don't-care outside the accept edge.
- **start level-sensitive:** if start stays high in DONE, a new operation begins on the next edge.
- **Output mux:** uo_out = sel ? {4'b0, remainder} : quotient. The mux is combinational from registered results.
- **Arithmetic:** unsigned only. Guaranteed: quotient*divisor + remainder = dividend, with remainder < divisor, for every divisor != 0.

## Timing
- **Reset (async, immediate):**
  - state=IDLE, quotient=0, remainder=0, busy=0, done=0.
  - Therefore uo_out=0 and uio_out=0.
  - uio_oe is constant and unaffected.
- **Accept edge:** call it edge E0.
  - busy=1 is visible after E0.
  - CALC steps occur on E1..E8.
  - busy=0, done=1 and valid results are visible after E8, i.e. 8 cycles from the accept edge.
- **Divide-by-zero:** done=1 and results are visible after E0 (latency 0 after accept). busy never asserts.
- **Back-to-back:** start held high continuously gives one result every 9 cycles (DONE state lasts one cycle).
- **Reset mid-CALC:** the operation is aborted, and no partial result is ever exposed. The first accept after reset release behaves normally.
- **sel change:** reflected on uo_out in the same cycle, with no state effect.

## Configuration
- **DIV_REMAINDER_EN defined:** remainder register and select mux are present, as described above.
- **DIV_REMAINDER_EN undefined:**
  - No remainder output register.
  - uo_out = quotient regardless of uio_in[5].
  - uio_in[5] joins the unused-signal reduction.
  - The internal partial remainder still exists for the algorithm.
  - Divide-by-zero still yields quotient 8'hFF.

## Test plan
- Dividend 8'hE1, divisor 4'hF, start pulse → busy high for 8 cycles, then done=1, quotient 8'h0F, remainder 4'h0 with sel=1.
- Dividend 200, divisor 7 → quotient 8'h1C (28), remainder 4'h4. Dividend 9, divisor 10 → quotient 8'h00, remainder 4'h9.
- Dividend 8'h5A, divisor 0 → done=1 immediately after the accept edge, busy stays 0, quotient 8'hFF, remainder 4'h0.
- Start 40/3. Mid-CALC, change the operands to 255/1 and pulse start → result remains quotient 8'h0D, remainder 4'h1. Start held high from DONE then produces 255/1 → quotient 8'hFF, remainder 0.
- Assert rst_n=0 at the 4th CALC cycle → uo_out=0, busy=0, done=0 asynchronously. After release, 100/9 → quotient 8'h0B, remainder 4'h1.
- Build without DIV_REMAINDER_EN: 200/7 with sel=1 → uo_out = 8'h1C. Exhaustive sweep of all 4096 operand pairs matches the reference model (divisor 0 → 8'hFF).
